// File: rtl/multi_oneshot_if.sv
// Signal bundle for the multi-channel oneshot: triggers and controls in, pulses and status out.
// MULTI_ONESHOT_MISS_CNT_EN adds the missed-trigger counter clear and readout.
interface multi_oneshot_if #(
  parameter int CHANNELS   = 4,
  parameter int DELAY_BITS = 21
);
  logic [CHANNELS-1:0]   ina;
  logic [CHANNELS-1:0]   en;
  logic                  edge_mode;
  logic [DELAY_BITS-1:0] holdoff;
  logic [CHANNELS-1:0]   outpulse;
  logic [CHANNELS-1:0]   busy;
`ifdef MULTI_ONESHOT_MISS_CNT_EN
  logic                  clr_missed;
  logic [CHANNELS*8-1:0] missed_cnt;

  modport master (
    output ina, en, edge_mode, holdoff, clr_missed,
    input  outpulse, busy, missed_cnt
  );
  modport slave (
    input  ina, en, edge_mode, holdoff, clr_missed,
    output outpulse, busy, missed_cnt
  );
`else
  modport master (
    output ina, en, edge_mode, holdoff,
    input  outpulse, busy
  );
  modport slave (
    input  ina, en, edge_mode, holdoff,
    output outpulse, busy
  );
`endif
endinterface

// File: rtl/multi_oneshot.sv
// Multi-channel synchronised oneshot with per-channel pulse + programmable holdoff window.
// Optional missed-trigger counters are built when MULTI_ONESHOT_MISS_CNT_EN is defined.
//
// state   | meaning
// IDLE    | armed, waiting for trig
// PULSE   | driving outpulse for PULSE_WIDTH cycles
// HOLDOFF | pulse done, waiting out the rest of the latched window
module multi_oneshot #(
  parameter int CHANNELS    = 4,
  parameter int DELAY_BITS  = 21,
  parameter int PULSE_WIDTH = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  multi_oneshot_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam logic [DELAY_BITS-1:0] PW    = DELAY_BITS'(PULSE_WIDTH);
  localparam logic [DELAY_BITS-1:0] PW_M1 = DELAY_BITS'(PULSE_WIDTH - 1);
  localparam logic [DELAY_BITS-1:0] ONE   = DELAY_BITS'(1);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] prev_q;
  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] trig;
  logic [CHANNELS-1:0] pulse_v;
  logic [CHANNELS-1:0] busy_v;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= bus.ina;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q <= s;
    end
  end

  // edge_mode is applied combinationally so a mode change affects trig in the same cycle
  assign trig = bus.en & s & (bus.edge_mode ? ~prev_q : {CHANNELS{1'b1}});

`ifdef MULTI_ONESHOT_MISS_CNT_EN
  logic [CHANNELS*8-1:0] miss_v;
  assign bus.missed_cnt = miss_v;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t                state_q, state_d;
    logic [DELAY_BITS-1:0] rem_q, rem_d;
    logic [DELAY_BITS-1:0] hold_q, hold_d;
    logic                  pulse_q, busy_q;

    // rem counts down the cycles left in the current state; hold is the holdoff
    // tail beyond the pulse, i.e. max(holdoff, PULSE_WIDTH) - PULSE_WIDTH
    always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      hold_d  = hold_q;
      case (state_q)
        IDLE: begin
          if (trig[i]) begin
            state_d = PULSE;
            rem_d   = PW_M1;
            hold_d  = (bus.holdoff > PW) ? (bus.holdoff - PW) : '0;
          end
        end
        PULSE: begin
          if (rem_q == '0) begin
            if (hold_q == '0) begin
              state_d = IDLE;
            end else begin
              state_d = HOLDOFF;
              rem_d   = hold_q - ONE;
            end
          end else begin
            rem_d = rem_q - ONE;
          end
        end
        HOLDOFF: begin
          if (rem_q == '0) state_d = IDLE;
          else             rem_d   = rem_q - ONE;
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= IDLE;
        rem_q   <= '0;
        hold_q  <= '0;
        pulse_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        rem_q   <= rem_d;
        hold_q  <= hold_d;
        pulse_q <= (state_d == PULSE);
        busy_q  <= (state_d != IDLE);
      end
    end

    assign pulse_v[i] = pulse_q;
    assign busy_v[i]  = busy_q;

`ifdef MULTI_ONESHOT_MISS_CNT_EN
    logic [7:0] miss_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        miss_q <= '0;
      end else if (bus.clr_missed) begin
        miss_q <= '0;
      end else if (trig[i] && (state_q != IDLE) && (miss_q != 8'hFF)) begin
        miss_q <= miss_q + 8'd1;
      end
    end

    assign miss_v[8*i +: 8] = miss_q;
`endif
  end

  assign bus.outpulse = pulse_v;
  assign bus.busy     = busy_v;

endmodule

// File: tb/tb_multi_oneshot.sv
// Directed bench for multi_oneshot: a PULSE_WIDTH=1 and a PULSE_WIDTH=3 instance on shared stimulus.
module tb_multi_oneshot;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  multi_oneshot_if #(.CHANNELS(4), .DELAY_BITS(21)) bif ();
  multi_oneshot_if #(.CHANNELS(4), .DELAY_BITS(21)) bif3 ();

  assign bif3.ina       = bif.ina;
  assign bif3.en        = bif.en;
  assign bif3.edge_mode = bif.edge_mode;
  assign bif3.holdoff   = bif.holdoff;
`ifdef MULTI_ONESHOT_MISS_CNT_EN
  assign bif3.clr_missed = bif.clr_missed;
`endif

  multi_oneshot #(.CHANNELS(4), .DELAY_BITS(21), .PULSE_WIDTH(1), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bif)
  );
  multi_oneshot #(.CHANNELS(4), .DELAY_BITS(21), .PULSE_WIDTH(3), .SYNC_STAGES(2)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bif3)
  );

  typedef struct {
    logic [3:0]  ina;
    logic [3:0]  en;
    logic        em;
    logic [20:0] ho;
    logic [3:0]  exp_out;
    logic [3:0]  exp_busy;
    logic [3:0]  exp_out3;
    logic [3:0]  exp_busy3;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] i, input logic [3:0] e, input logic m, input logic [20:0] h,
                     input logic [3:0] o, input logic [3:0] b, input logic [3:0] o3, input logic [3:0] b3);
    vec_t v;
    v.ina = i; v.en = e; v.em = m; v.ho = h;
    v.exp_out = o; v.exp_busy = b; v.exp_out3 = o3; v.exp_busy3 = b3;
    vq.push_back(v);
  endtask

  initial begin
    // level-mode ch0, holdoff 3 (main period 4, dut3 Wl=3 period 4)
    add(4'h1, 4'hF, 1'b0, 21'd3, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h1, 4'hF, 1'b0, 21'd3, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h1, 4'hF, 1'b0, 21'd3, 4'h1, 4'h1, 4'h1, 4'h1);
    add(4'h1, 4'hF, 1'b0, 21'd3, 4'h0, 4'h1, 4'h1, 4'h1);
    add(4'h1, 4'hF, 1'b0, 21'd3, 4'h0, 4'h1, 4'h1, 4'h1);
    add(4'h1, 4'hF, 1'b0, 21'd3, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h1, 4'hF, 1'b0, 21'd3, 4'h1, 4'h1, 4'h1, 4'h1);
    add(4'h1, 4'hF, 1'b0, 21'd3, 4'h0, 4'h1, 4'h1, 4'h1);
    add(4'h1, 4'hF, 1'b0, 21'd3, 4'h0, 4'h1, 4'h1, 4'h1);
    add(4'h1, 4'hF, 1'b0, 21'd3, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h1, 4'hF, 1'b0, 21'd3, 4'h1, 4'h1, 4'h1, 4'h1);
    // en dropped mid-window: window completes, re-trigger blocked
    add(4'h1, 4'hE, 1'b0, 21'd3, 4'h0, 4'h1, 4'h1, 4'h1);
    add(4'h1, 4'hE, 1'b0, 21'd3, 4'h0, 4'h1, 4'h1, 4'h1);
    add(4'h1, 4'hE, 1'b0, 21'd3, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h1, 4'hE, 1'b0, 21'd3, 4'h0, 4'h0, 4'h0, 4'h0);
    // holdoff 0 behaves as PULSE_WIDTH
    add(4'h1, 4'hF, 1'b0, 21'd0, 4'h1, 4'h1, 4'h1, 4'h1);
    add(4'h1, 4'hF, 1'b0, 21'd0, 4'h0, 4'h0, 4'h1, 4'h1);
    add(4'h1, 4'hF, 1'b0, 21'd0, 4'h1, 4'h1, 4'h1, 4'h1);
    add(4'h1, 4'hF, 1'b0, 21'd0, 4'h0, 4'h0, 4'h0, 4'h0);
    // input drops; sync pipeline still delivers one more trigger
    add(4'h0, 4'hF, 1'b0, 21'd2, 4'h1, 4'h1, 4'h1, 4'h1);
    add(4'h0, 4'hF, 1'b0, 21'd2, 4'h0, 4'h1, 4'h1, 4'h1);
    add(4'h0, 4'hF, 1'b0, 21'd2, 4'h0, 4'h0, 4'h1, 4'h1);
    add(4'h0, 4'hF, 1'b0, 21'd2, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h0, 4'hF, 1'b0, 21'd2, 4'h0, 4'h0, 4'h0, 4'h0);
    // holdoff 2: main period 3, dut3 3-cycle pulse with period 4
    add(4'h1, 4'hF, 1'b0, 21'd2, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h1, 4'hF, 1'b0, 21'd2, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h1, 4'hF, 1'b0, 21'd2, 4'h1, 4'h1, 4'h1, 4'h1);
    add(4'h1, 4'hF, 1'b0, 21'd2, 4'h0, 4'h1, 4'h1, 4'h1);
    add(4'h1, 4'hF, 1'b0, 21'd2, 4'h0, 4'h0, 4'h1, 4'h1);
    add(4'h1, 4'hF, 1'b0, 21'd2, 4'h1, 4'h1, 4'h0, 4'h0);
    add(4'h1, 4'hF, 1'b0, 21'd2, 4'h0, 4'h1, 4'h1, 4'h1);
    add(4'h1, 4'hF, 1'b0, 21'd2, 4'h0, 4'h0, 4'h1, 4'h1);
    add(4'h1, 4'hF, 1'b0, 21'd2, 4'h1, 4'h1, 4'h1, 4'h1);

    // reset with all inputs already high, edge mode
    bif.ina = 4'hF; bif.en = 4'hF; bif.edge_mode = 1'b1; bif.holdoff = 21'd10;
`ifdef MULTI_ONESHOT_MISS_CNT_EN
    bif.clr_missed = 1'b0;
`endif
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst out", bif.outpulse, 4'h0);
    chk("rst busy", bif.busy, 4'h0);
    chk("rst out3", bif3.outpulse, 4'h0);
    chk("rst busy3", bif3.busy, 4'h0);
    @(negedge clk) reset_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      chk($sformatf("rel c%0d out", n), bif.outpulse, (n == 3) ? 4'hF : 4'h0);
      chk($sformatf("rel c%0d busy", n), bif.busy, (n >= 3 && n <= 12) ? 4'hF : 4'h0);
      chk($sformatf("rel c%0d out3", n), bif3.outpulse, (n >= 3 && n <= 5) ? 4'hF : 4'h0);
      chk($sformatf("rel c%0d busy3", n), bif3.busy, (n >= 3 && n <= 12) ? 4'hF : 4'h0);
    end

    @(negedge clk) bif.ina = 4'h0;
    repeat (4) @(posedge clk);

    foreach (vq[r]) begin
      @(negedge clk);
      bif.ina = vq[r].ina; bif.en = vq[r].en; bif.edge_mode = vq[r].em; bif.holdoff = vq[r].ho;
      @(posedge clk); #1;
      chk($sformatf("row%0d out", r), bif.outpulse, vq[r].exp_out);
      chk($sformatf("row%0d busy", r), bif.busy, vq[r].exp_busy);
      chk($sformatf("row%0d out3", r), bif3.outpulse, vq[r].exp_out3);
      chk($sformatf("row%0d busy3", r), bif3.busy, vq[r].exp_busy3);
    end

    // edge mode ch1: second edge inside holdoff 20 ignored, third after busy drops fires
    @(negedge clk);
    bif.ina = 4'h0; bif.en = 4'hF; bif.edge_mode = 1'b1; bif.holdoff = 21'd20;
    repeat (8) @(posedge clk);
    for (int n = 0; n <= 31; n++) begin
      @(negedge clk);
      bif.ina[1] = (n < 4) || (n >= 8 && n < 12) || (n >= 26);
      @(posedge clk); #1;
      chk($sformatf("edge n%0d out", n), bif.outpulse, (n == 2 || n == 28) ? 4'h2 : 4'h0);
      chk($sformatf("edge n%0d busy", n), bif.busy,
          ((n >= 2 && n <= 21) || n >= 28) ? 4'h2 : 4'h0);
      chk($sformatf("edge n%0d out3", n), bif3.outpulse,
          ((n >= 2 && n <= 4) || (n >= 28 && n <= 30)) ? 4'h2 : 4'h0);
    end

    // async reset in the middle of a ch2 pulse
    @(negedge clk) bif.ina = 4'h6;
    repeat (3) @(posedge clk);
    #1;
    chk("pre-rst out", bif.outpulse, 4'h4);
    chk("pre-rst out3", bif3.outpulse, 4'h4);
    #1 reset_n = 1'b0;
    #1;
    chk("async out", bif.outpulse, 4'h0);
    chk("async busy", bif.busy, 4'h0);
    chk("async out3", bif3.outpulse, 4'h0);
    chk("async busy3", bif3.busy, 4'h0);

`ifdef MULTI_ONESHOT_MISS_CNT_EN
    bif.ina = 4'h8; bif.edge_mode = 1'b0; bif.holdoff = 21'd300; bif.clr_missed = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    for (int n = 1; n <= 292; n++) begin
      @(posedge clk); #1;
      if (n == 103) begin
        chk("miss c103", bif.missed_cnt[31:24], 8'd100);
        chk("miss3 c103", bif3.missed_cnt[31:24], 8'd100);
      end
      if (n == 290) begin
        chk("miss sat", bif.missed_cnt[31:24], 8'd255);
        chk("miss3 sat", bif3.missed_cnt[31:24], 8'd255);
        chk("miss others", bif.missed_cnt[23:0], 24'd0);
      end
      if (n == 291) begin
        chk("miss clr", bif.missed_cnt[31:24], 8'd0);
        chk("miss3 clr", bif3.missed_cnt[31:24], 8'd0);
      end
      if (n == 292) chk("miss after clr", bif.missed_cnt[31:24], 8'd1);
      bif.clr_missed = (n + 1 == 291);
    end
`else
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(posedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_oneshot.md
Name: multi_oneshot

Overview:
Parametrised multi-channel successor to the single-channel pulse oneshot. Each of CHANNELS independent channels synchronises its raw input, detects a level or rising-edge trigger, emits a PULSE_WIDTH-cycle pulse, then holds off for a runtime-programmable window before it re-arms. It sits between push-buttons/switches or slow strobes and the clocked control logic, and rate-limits events such as display steps, counter increments and motor steps.

Parameters:
CHANNELS, 4, number of independent oneshot channels
DELAY_BITS, 21, width of the holdoff counter and of the holdoff input
PULSE_WIDTH, 1, output pulse length in clk cycles; legal range 1 to 2^DELAY_BITS-1
SYNC_STAGES, 2, input synchroniser depth; minimum 1

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
ina  input  CHANNELS  raw trigger inputs, asynchronous to clk
en  input  CHANNELS  per-channel arm enable
edge_mode  input  1  1 = trigger on rising edge of synchronised input; 0 = trigger on high level
holdoff  input  DELAY_BITS  re-arm window length W in cycles, shared by all channels
outpulse  output  CHANNELS  registered output pulses
busy  output  CHANNELS  high while a channel is in PULSE or HOLDOFF

Behaviour:
- Reset (reset_n low, async): all synchroniser flops, previous-sample flops and counters clear to 0; every channel goes to IDLE; outpulse = 0 and busy = 0. A channel reset mid-pulse drops its pulse immediately.
- Synchroniser: ina[i] passes through SYNC_STAGES flops to give s[i]. p[i] is s[i] delayed by one clock.
- Trigger: trig[i] = en[i] & s[i] & (edge_mode ? ~p[i] : 1). After reset p = 0, so an input already high gives one edge trigger once it reaches s.
- Per-channel FSM, states IDLE, PULSE and HOLDOFF:
  - IDLE: when trig is high, on the next edge set count = 1, latch Wl = max(holdoff, PULSE_WIDTH), and go to PULSE. Otherwise stay in IDLE.
  - PULSE: outpulse = 1. Each cycle, count increments.
    - If count = PULSE_WIDTH and Wl = PULSE_WIDTH, go to IDLE.
    - Else if count = PULSE_WIDTH, go to HOLDOFF.
  - HOLDOFF: outpulse = 0. count increments; when count = Wl, go to IDLE.
- outpulse and busy are registered: both are high exactly when the state is PULSE (outpulse) or not IDLE (busy).
- Latency: from an ina edge to outpulse high is SYNC_STAGES+1 clocks. This ignores synchroniser metastability resolution.
- Repetition: with level mode and the input held high, the pulse-start period is Wl+1 cycles.
- Triggers seen while a channel is not in IDLE are ignored; there is no retrigger extension.
- holdoff is sampled only at trigger. A mid-window change affects the next trigger only. holdoff = 0 acts as PULSE_WIDTH.
- count never exceeds Wl, so it cannot wrap.
- Deasserting en during PULSE or HOLDOFF does not truncate the window. It only blocks the next trigger.
- A change of edge_mode takes effect on trig in the same cycle. Switching 0→1 while s is high does not produce an edge.
- Channels are fully independent. Simultaneous triggers on all channels produce simultaneous pulses.

Optional Feature:
Macro MULTI_ONESHOT_MISS_CNT_EN.
- Defined: adds input clr_missed (1 bit) and output missed_cnt (CHANNELS*8 bits, channel i in bits [8i+7:8i]).
  - Each cycle in which the trig condition holds while the channel is not IDLE increments that channel's counter, saturating at 255.
  - clr_missed zeroes all counters; clear wins over a simultaneous increment.
  - reset_n clears the counters.
- Not defined: these ports and registers are absent, and the rest of the behaviour is identical.

Test Plan:
- Reset with ina = 4'b1111, edge_mode = 1, en = all 1, SYNC_STAGES = 2, PULSE_WIDTH = 1, holdoff = 10; release reset_n → exactly one 1-cycle pulse per channel at cycle 3 after release, busy for 10 cycles, then no further pulses while ina stays high.
- Level mode, ch0 held high, holdoff = 3, PULSE_WIDTH = 1 → outpulse[0] pulses every 4 cycles; other channels stay 0.
- PULSE_WIDTH = 3, holdoff = 2 → outpulse high 3 cycles, busy 3 cycles, and the next level-mode pulse starts 4 cycles after the previous one starts.
- Edge mode, ch1 gets a second rising edge inside holdoff = 20 → no second pulse. A third edge after busy falls gives a pulse.
- Assert reset_n low mid-PULSE on ch2 → outpulse[2] and busy[2] go 0 asynchronously, before the next clk edge.
- With MULTI_ONESHOT_MISS_CNT_EN defined, level mode, holdoff = 300, ch3 held high → missed_cnt[31:24] saturates at 255. Pulsing clr_missed returns it to 0.
